rc4_phase_ctrl: RTL and testbench



---
 rtl/rc4_phase_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_rc4_phase_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_phase_ctrl
//   Phase sequencer for the RC4 core. Walks the S-box engine through
//   IDLE -> INIT (S[i]=i fill) -> KSA -> READY, and from READY runs keystream
//   (PRGA) requests of a given byte length. Every output is registered.
//
// Parameters
//   LEN_W    width of req_len and byte_cnt
//   TIMEOUT  watchdog limit in cycles per engine phase (RC4_WDOG_EN only)
//
// Optional feature (macro RC4_WDOG_EN)
//   Adds a per-phase cycle watchdog and the wdog_trip output. Without the
//   macro the controller waits indefinitely for the engine.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   key_setup_en   rekey request (single-cycle sample)
//   cipher_req     keystream request (single-cycle sample), length on req_len
//   init_done      engine finished the S-box fill
//   ksa_done       engine finished the key schedule
//   ks_valid       engine produced one keystream byte this cycle
//   init_start     pulse: begin S-box fill
//   ksa_start      pulse: begin KSA
//   prga_en        level: engine may generate keystream bytes
//   key_ready      S-box holds a valid keyed state
//   busy           controller is in INIT, KSA or PRGA
//   done           pulse: request complete
//   reject         pulse: request refused (or watchdog abort)
//   byte_cnt       bytes delivered in the current/last request
//   wdog_trip      pulse: watchdog expired (RC4_WDOG_EN only)
// -----------------------------------------------------------------------------
module rc4_phase_ctrl #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_setup_en,
    input  logic             cipher_req,
    input  logic [LEN_W-1:0] req_len,
    input  logic             init_done,
    input  logic             ksa_done,
    input  logic             ks_valid,
    output logic             init_start,
    output logic             ksa_start,
    output logic             prga_en,
    output logic             key_ready,
    output logic             busy,
    output logic             done,
    output logic             reject,
    output logic [LEN_W-1:0] byte_cnt
`ifdef RC4_WDOG_EN
    ,
    output logic             wdog_trip
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KSA,
        S_READY,
        S_PRGA
    } state_e;

    state_e           state_q, state_d;
    logic             init_start_q, init_start_d;
    logic             ksa_start_q, ksa_start_d;
    logic             prga_en_q, prga_en_d;
    logic             key_ready_q, key_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             reject_q, reject_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_inc;

`ifdef RC4_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            trip_q, trip_d;
    logic            progress;
`else
    // TIMEOUT has no effect without the watchdog; it stays in the parameter
    // list so both builds share one instantiation template.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        init_start_d = 1'b0;
        ksa_start_d  = 1'b0;
        done_d       = 1'b0;
        reject_d     = 1'b0;
        prga_en_d    = prga_en_q;
        key_ready_d  = key_ready_q;
        cnt_d        = cnt_q;
        len_d        = len_q;

        case (state_q)
            S_IDLE: begin
                if (key_setup_en) begin
                    state_d      = S_INIT;
                    init_start_d = 1'b1;
                    reject_d     = cipher_req;
                end else if (cipher_req) begin
                    reject_d = 1'b1;
                end
            end
            S_INIT: begin
                reject_d = key_setup_en | cipher_req;
                if (init_done) begin
                    state_d     = S_KSA;
                    ksa_start_d = 1'b1;
                end
            end
            S_KSA: begin
                reject_d = key_setup_en | cipher_req;
                if (ksa_done) begin
                    state_d     = S_READY;
                    key_ready_d = 1'b1;
                end
            end
            S_READY: begin
                // Rekey has priority over a simultaneous cipher request.
                if (key_setup_en) begin
                    state_d      = S_INIT;
                    init_start_d = 1'b1;
                    key_ready_d  = 1'b0;
                    reject_d     = cipher_req;
                end else if (cipher_req) begin
                    cnt_d = '0;
                    if (req_len != '0) begin
                        len_d     = req_len;
                        state_d   = S_PRGA;
                        prga_en_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PRGA: begin
                reject_d = key_setup_en | cipher_req;
                if (ks_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d   = S_READY;
                        prga_en_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                prga_en_d = 1'b0;
            end
        endcase

`ifdef RC4_WDOG_EN
        // The counter measures cycles without progress in the current phase.
        progress = (state_d != state_q) || ((state_q == S_PRGA) && ks_valid);
        trip_d   = 1'b0;
        wd_d     = '0;
        if ((state_q == S_INIT) || (state_q == S_KSA) || (state_q == S_PRGA)) begin
            if (progress) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d     = S_IDLE;
                key_ready_d = 1'b0;
                prga_en_d   = 1'b0;
                reject_d    = 1'b1;
                trip_d      = 1'b1;
                done_d      = 1'b0;
                wd_d        = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif

        busy_d = (state_d == S_INIT) || (state_d == S_KSA) || (state_d == S_PRGA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_en_q    <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reject_q     <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
`ifdef RC4_WDOG_EN
            wd_q         <= '0;
            trip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            init_start_q <= init_start_d;
            ksa_start_q  <= ksa_start_d;
            prga_en_q    <= prga_en_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            reject_q     <= reject_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
`ifdef RC4_WDOG_EN
            wd_q         <= wd_d;
            trip_q       <= trip_d;
`endif
        end
    end

    assign init_start = init_start_q;
    assign ksa_start  = ksa_start_q;
    assign prga_en    = prga_en_q;
    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign reject     = reject_q;
    assign byte_cnt   = cnt_q;
`ifdef RC4_WDOG_EN
    assign wdog_trip  = trip_q;
`endif

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rc4_phase_ctrl
//   Scoreboard bench for rc4_phase_ctrl. The stimulus side keeps a phase-level
//   model of the controller and queues every expected pulse together with the
//   cycle it must appear in; a monitor on the falling edge retires queue
//   entries as pulses show up. Level outputs are compared against the model
//   after every driven cycle.
// -----------------------------------------------------------------------------
module tb_rc4_phase_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_setup_en = 1'b0;
    logic             cipher_req = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             init_done = 1'b0;
    logic             ksa_done = 1'b0;
    logic             ks_valid = 1'b0;
    logic             init_start, ksa_start, prga_en, key_ready, busy, done, reject;
    logic [LEN_W-1:0] byte_cnt;
`ifdef RC4_WDOG_EN
    logic             wdog_trip;
`endif

    rc4_phase_ctrl #(.LEN_W(LEN_W), .TIMEOUT(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_setup_en (key_setup_en),
        .cipher_req   (cipher_req),
        .req_len      (req_len),
        .init_done    (init_done),
        .ksa_done     (ksa_done),
        .ks_valid     (ks_valid),
        .init_start   (init_start),
        .ksa_start    (ksa_start),
        .prga_en      (prga_en),
        .key_ready    (key_ready),
        .busy         (busy),
        .done         (done),
        .reject       (reject),
        .byte_cnt     (byte_cnt)
`ifdef RC4_WDOG_EN
        ,
        .wdog_trip    (wdog_trip)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse kinds: 0 init_start, 1 ksa_start, 2 done, 3 reject
    localparam int K_INIT = 0, K_KSA = 1, K_DONE = 2, K_REJ = 3;
    string kname[4] = '{"init_start", "ksa_start", "done", "reject"};

    typedef struct {
        int               kind;
        int unsigned      at;
        logic [LEN_W-1:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    // Phase-level reference model
    typedef enum {M_IDLE, M_INIT, M_KSA, M_READY, M_PRGA} mph_e;
    mph_e             m_ph  = M_IDLE;
    logic             m_key = 1'b0;
    logic [LEN_W-1:0] m_cnt = '0;
    logic [LEN_W-1:0] m_len = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input int kind, input logic [LEN_W-1:0] cnt);
        exp_t e;
        e.kind = kind;
        e.at   = cyc + 1;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    function automatic bit m_busy();
        return (m_ph == M_INIT) || (m_ph == M_KSA) || (m_ph == M_PRGA);
    endfunction

    // Called at posedge+1: presents inputs for one cycle, updates the model,
    // then compares the level outputs after the sampling edge.
    task automatic drive(input logic kse, input logic cr, input logic [LEN_W-1:0] len,
                         input logic id, input logic kd, input logic kv);
        key_setup_en = kse;
        cipher_req   = cr;
        req_len      = len;
        init_done    = id;
        ksa_done     = kd;
        ks_valid     = kv;
        case (m_ph)
            M_IDLE, M_READY: begin
                if (kse) begin
                    expect_pulse(K_INIT, m_cnt);
                    if (cr) expect_pulse(K_REJ, m_cnt);
                    m_ph  = M_INIT;
                    m_key = 1'b0;
                end else if (cr) begin
                    if (m_ph == M_IDLE) begin
                        expect_pulse(K_REJ, m_cnt);
                    end else if (len == 0) begin
                        m_cnt = '0;
                        expect_pulse(K_DONE, '0);
                    end else begin
                        m_cnt = '0;
                        m_len = len;
                        m_ph  = M_PRGA;
                    end
                end
            end
            default: begin
                if (kse || cr) expect_pulse(K_REJ, m_cnt);
                if (m_ph == M_INIT && id) begin
                    expect_pulse(K_KSA, m_cnt);
                    m_ph = M_KSA;
                end else if (m_ph == M_KSA && kd) begin
                    m_ph  = M_READY;
                    m_key = 1'b1;
                end else if (m_ph == M_PRGA && kv) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == m_len) begin
                        expect_pulse(K_DONE, m_cnt);
                        m_ph = M_READY;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
        key_setup_en = 1'b0;
        cipher_req   = 1'b0;
        init_done    = 1'b0;
        ksa_done     = 1'b0;
        ks_valid     = 1'b0;
        check("key_ready", key_ready, m_key);
        check("prga_en", prga_en, m_ph == M_PRGA);
        check("busy", busy, m_busy());
        check("byte_cnt", byte_cnt, m_cnt);
    endtask

    // Idle cycles with random noise the current phase must ignore: stray
    // completion strobes of other phases, and refused requests while busy.
    task automatic gap(input int n);
        logic kse, cr, id, kd, kv;
        for (int i = 0; i < n; i++) begin
            kse = 1'b0;
            cr  = 1'b0;
            if (m_busy() && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) kse = 1'b1;
                else cr = 1'b1;
            end
            id = (m_ph != M_INIT) && ($urandom_range(0, 5) == 0);
            kd = (m_ph != M_KSA)  && ($urandom_range(0, 5) == 0);
            kv = (m_ph != M_PRGA) && ($urandom_range(0, 5) == 0);
            drive(kse, cr, LEN_W'($urandom), id, kd, kv);
        end
    endtask

    task automatic rekey(input int g1, input int g2, input logic with_cr);
        drive(1'b1, with_cr, LEN_W'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b0);
        gap(g1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        gap(g2);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic cipher(input logic [LEN_W-1:0] len, input int max_gap);
        drive(1'b0, 1'b1, len, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < int'(len); k++) begin
            gap($urandom_range(0, max_gap));
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " init_start"}, init_start, 1'b0);
        check({tag, " ksa_start"}, ksa_start, 1'b0);
        check({tag, " prga_en"}, prga_en, 1'b0);
        check({tag, " key_ready"}, key_ready, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " reject"}, reject, 1'b0);
        check({tag, " byte_cnt"}, byte_cnt, '0);
    endtask

    // Monitor: retire one queued expectation per observed pulse and flag
    // expectations whose cycle has passed without the pulse.
    always @(negedge clk) begin
        logic [3:0] p;
        int idx;
        if (rst_n) begin
            p = {reject, done, ksa_start, init_start};
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].kind == k) idx = i;
                    if (idx < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s: unexpected pulse at cycle %0d, required none", kname[k], cyc);
                    end else begin
                        check({kname[k], " cycle"}, cyc, exp_q[idx].at);
                        if (k == K_DONE) check("done byte_cnt", byte_cnt, exp_q[idx].cnt);
                        exp_q.delete(idx);
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].at <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: no pulse seen, required at cycle %0d", kname[exp_q[i].kind], exp_q[i].at);
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Cipher request before any key: refused, stays idle
        drive(1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
        gap(4);

        // Full key setup with long engine phases
        rekey(255, 511, 1'b0);
        gap(3);

        // Two requests: keystream continues, counter restarts each time
        cipher(16'd3, 3);
        gap(2);
        cipher(16'd2, 2);
        gap(2);

        // Zero-length request completes at once
        cipher(16'd0, 0);
        gap(2);

        // Simultaneous rekey and cipher request: rekey wins
        rekey(6, 6, 1'b1);
        gap(2);

        // Randomized mix of operations
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0:       rekey($urandom_range(0, 12), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
                1:       gap($urandom_range(1, 6));
                default: cipher(LEN_W'($urandom_range(0, 9)), $urandom_range(0, 4));
            endcase
        end
        gap(2);

        // Asynchronous reset in the middle of a keystream request
        drive(1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_ph  = M_IDLE;
        m_key = 1'b0;
        m_cnt = '0;
        m_len = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1);
        gap(4);

        check("pending expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
